// File: rtl/jtag_tap_target.sv
// rtl/jtag_tap_target.sv - JTAG TAP target oversampled on CLK with IDCODE, BYPASS and USER data registers.
module jtag_tap_target #(
    parameter int                IR_LEN    = 4,
    parameter logic [31:0]       IDCODE    = 32'h4BA00477,
    parameter int                USER_LEN  = 35,
    parameter logic [IR_LEN-1:0] IR_IDCODE = 4'hE,
    parameter logic [IR_LEN-1:0] IR_USER   = 4'hA
) (
    input  logic                CLK,
    input  logic                SYS_RESETn,
    input  logic                TCK,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_OE,
    output logic [3:0]          STATE,
    output logic [IR_LEN-1:0]   IR,
    input  logic [USER_LEN-1:0] CAP_DATA,
    output logic                CAP_STB,
    output logic [USER_LEN-1:0] UPD_DATA,
    output logic                UPD_VALID,
    output logic                TAP_RESETn
);

    typedef enum logic [3:0] {
        RUNTEST_IDLE = 4'h0, SELECT_DR  = 4'h1, SHIFT_DR   = 4'h2, UPDATE_DR  = 4'h3,
        CAPTURE_DR   = 4'h4, EXIT1_DR   = 4'h5, PAUSE_DR   = 4'h6, EXIT2_DR   = 4'h7,
        LOGIC_RESET  = 4'h8, SELECT_IR  = 4'h9, SHIFT_IR   = 4'hA, UPDATE_IR  = 4'hB,
        CAPTURE_IR   = 4'hC, EXIT1_IR   = 4'hD, PAUSE_IR   = 4'hE, EXIT2_IR   = 4'hF
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    tap_state_t          state;
    tap_state_t          next_state;
    logic                tck_m, tck_s, tck_d;
    logic                tms_m, tms_s;
    logic                tdi_m, tdi_s;
    logic                rise, fall;
    logic [IR_LEN-1:0]   ir_sr;
    logic [31:0]         id_sr;
    logic [USER_LEN-1:0] user_sr;
    logic                bypass;
    logic                upd_dr_pend, upd_ir_pend;
    logic                sel_idcode, sel_user;
    logic                dr_lsb;

    assign rise       = tck_s & ~tck_d;
    assign fall       = ~tck_s & tck_d;
    assign sel_idcode = (IR == IR_IDCODE);
    assign sel_user   = (IR == IR_USER);
    assign dr_lsb     = sel_idcode ? id_sr[0] : (sel_user ? user_sr[0] : bypass);
    assign STATE      = state;
    assign TDO_OE     = (state == SHIFT_DR) || (state == SHIFT_IR);
    assign TAP_RESETn = (state != LOGIC_RESET);

    always_comb begin
        next_state = LOGIC_RESET;
        case (state)
            LOGIC_RESET:  next_state = tms_s ? LOGIC_RESET : RUNTEST_IDLE;
            RUNTEST_IDLE: next_state = tms_s ? SELECT_DR   : RUNTEST_IDLE;
            SELECT_DR:    next_state = tms_s ? SELECT_IR   : CAPTURE_DR;
            CAPTURE_DR:   next_state = tms_s ? EXIT1_DR    : SHIFT_DR;
            SHIFT_DR:     next_state = tms_s ? EXIT1_DR    : SHIFT_DR;
            EXIT1_DR:     next_state = tms_s ? UPDATE_DR   : PAUSE_DR;
            PAUSE_DR:     next_state = tms_s ? EXIT2_DR    : PAUSE_DR;
            EXIT2_DR:     next_state = tms_s ? UPDATE_DR   : SHIFT_DR;
            UPDATE_DR:    next_state = tms_s ? SELECT_DR   : RUNTEST_IDLE;
            SELECT_IR:    next_state = tms_s ? LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:   next_state = tms_s ? EXIT1_IR    : SHIFT_IR;
            SHIFT_IR:     next_state = tms_s ? EXIT1_IR    : SHIFT_IR;
            EXIT1_IR:     next_state = tms_s ? UPDATE_IR   : PAUSE_IR;
            PAUSE_IR:     next_state = tms_s ? EXIT2_IR    : PAUSE_IR;
            EXIT2_IR:     next_state = tms_s ? UPDATE_IR   : SHIFT_IR;
            UPDATE_IR:    next_state = tms_s ? SELECT_DR   : RUNTEST_IDLE;
            default:      next_state = LOGIC_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!SYS_RESETn) begin
            {tck_m, tck_s, tck_d} <= 3'b000;
            {tms_m, tms_s}        <= 2'b00;
            {tdi_m, tdi_s}        <= 2'b00;
            state       <= LOGIC_RESET;
            IR          <= IR_IDCODE;
            ir_sr       <= '0;
            id_sr       <= '0;
            user_sr     <= '0;
            bypass      <= 1'b0;
            TDO         <= 1'b0;
            CAP_STB     <= 1'b0;
            UPD_VALID   <= 1'b0;
            UPD_DATA    <= '0;
            upd_dr_pend <= 1'b0;
            upd_ir_pend <= 1'b0;
        end else begin
            {tck_m, tck_s, tck_d} <= {TCK, tck_m, tck_s};
            {tms_m, tms_s}        <= {TMS, tms_m};
            {tdi_m, tdi_s}        <= {TDI, tdi_m};
            CAP_STB     <= 1'b0;
            UPD_VALID   <= 1'b0;
            upd_dr_pend <= 1'b0;
            upd_ir_pend <= 1'b0;

            // Update actions fire on the CLK after the rise that entered UPDATE_xx.
            if (upd_ir_pend) IR <= ir_sr;
            if (upd_dr_pend && sel_user) begin
                UPD_DATA  <= user_sr;
                UPD_VALID <= 1'b1;
            end
            if (state == LOGIC_RESET) IR <= IR_IDCODE;

            if (rise) begin
                state       <= next_state;
                upd_dr_pend <= (next_state == UPDATE_DR);
                upd_ir_pend <= (next_state == UPDATE_IR);
                case (state)
                    CAPTURE_IR: ir_sr <= IR_CAPTURE;
                    SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                    CAPTURE_DR: begin
                        if (sel_idcode) id_sr <= IDCODE;
                        else if (sel_user) begin
                            user_sr <= CAP_DATA;
                            CAP_STB <= 1'b1;
                        end else bypass <= 1'b0;
                    end
                    SHIFT_DR: begin
                        if (sel_idcode)    id_sr   <= {tdi_s, id_sr[31:1]};
                        else if (sel_user) user_sr <= {tdi_s, user_sr[USER_LEN-1:1]};
                        else               bypass  <= tdi_s;
                    end
                    default: ;
                endcase
            end

            if (fall) begin
                if (state == SHIFT_DR)      TDO <= dr_lsb;
                else if (state == SHIFT_IR) TDO <= ir_sr[0];
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb/tb_jtag_tap_target.sv - Directed bench for jtag_tap_target: vector table plus multi-cycle sequences.
module tb_jtag_tap_target;

    logic        CLK = 1'b0;
    logic        SYS_RESETn = 1'b0;
    logic        TCK = 1'b0;
    logic        TMS = 1'b1;
    logic        TDI = 1'b0;
    logic        TDO, TDO_OE, CAP_STB, UPD_VALID, TAP_RESETn;
    logic [3:0]  STATE, IR;
    logic [34:0] CAP_DATA = '0;
    logic [34:0] UPD_DATA;

    jtag_tap_target dut (
        .CLK(CLK), .SYS_RESETn(SYS_RESETn), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_OE(TDO_OE), .STATE(STATE), .IR(IR),
        .CAP_DATA(CAP_DATA), .CAP_STB(CAP_STB), .UPD_DATA(UPD_DATA),
        .UPD_VALID(UPD_VALID), .TAP_RESETn(TAP_RESETn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       chk;
        logic       exp_tdo;
        logic [3:0] exp_state;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cap_cnt = 0;
    int   upd_cnt = 0;

    always @(negedge CLK) begin
        if (CAP_STB)   cap_cnt++;
        if (UPD_VALID) upd_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic tms, input logic tdi, input logic chk,
                                    input logic exp_tdo, input logic [3:0] st);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.chk = chk; v.exp_tdo = exp_tdo; v.exp_state = st;
        vecs.push_back(v);
    endfunction

    // One TCK period: fall, settle, sample TDO, rise, settle.
    task automatic tck_bit(input logic tms, input logic tdi, output logic tdo_s);
        @(negedge CLK);
        TCK = 1'b0; TMS = tms; TDI = tdi;
        repeat (6) @(negedge CLK);
        tdo_s = TDO;
        TCK = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
        logic t;
        tck_bit(1, 0, t); tck_bit(1, 0, t); tck_bit(0, 0, t); tck_bit(0, 0, t);
        for (int i = 0; i < 4; i++) begin
            tck_bit(i == 3, din[i], t);
            dout[i] = t;
        end
        tck_bit(1, 0, t); tck_bit(0, 0, t);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        logic t;
        dout = '0;
        tck_bit(1, 0, t); tck_bit(0, 0, t); tck_bit(0, 0, t);
        for (int i = 0; i < len; i++) begin
            tck_bit(i == len - 1, din[i], t);
            dout[i] = t;
        end
        tck_bit(1, 0, t); tck_bit(0, 0, t);
    endtask

    initial begin
        logic        t;
        logic [3:0]  ir_out;
        logic [63:0] dout;
        logic [31:0] idc;
        logic [34:0] din;
        int          c0, u0;

        idc = 32'h4BA00477;
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(1, 0, 0, 0, 4'h1);
        add_vec(0, 0, 0, 0, 4'h4);
        add_vec(0, 0, 0, 0, 4'h2);
        for (int k = 0; k < 31; k++) add_vec(0, 0, 1, idc[k], 4'h2);
        add_vec(1, 0, 1, idc[31], 4'h5);
        add_vec(1, 0, 0, 0, 4'h3);
        add_vec(0, 0, 0, 0, 4'h0);

        repeat (5) @(negedge CLK);
        check("rst_state", STATE, 4'h8);
        check("rst_ir", IR, 4'hE);
        check("rst_tdo", TDO, 0);
        check("rst_tdo_oe", TDO_OE, 0);
        check("rst_cap_stb", CAP_STB, 0);
        check("rst_upd_valid", UPD_VALID, 0);
        check("rst_upd_data", UPD_DATA, 0);
        check("rst_tap_resetn", TAP_RESETn, 0);
        SYS_RESETn = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_state", STATE, 4'h8);

        for (int i = 0; i < vecs.size(); i++) begin
            tck_bit(vecs[i].tms, vecs[i].tdi, t);
            if (vecs[i].chk) check($sformatf("idcode_vec%0d_tdo", i), t, vecs[i].exp_tdo);
            check($sformatf("idcode_vec%0d_state", i), STATE, vecs[i].exp_state);
        end

        shift_ir(4'hF, ir_out);
        check("ir_capture_bits", ir_out, 4'b0001);
        check("ir_bypass", IR, 4'hF);
        shift_dr(64'h0A5, 9, dout);
        check("bypass_stream", dout, 64'h14A);

        tck_bit(1, 0, t); tck_bit(1, 0, t); tck_bit(0, 0, t); tck_bit(0, 0, t);
        check("shift_ir_state", STATE, 4'hA);
        check("shift_ir_oe", TDO_OE, 1);
        for (int i = 0; i < 4; i++) begin
            tck_bit(i == 3, i[0] ? 1'b1 : 1'b0, t);
            ir_out[i] = t;
        end
        check("ir_out_before_update", IR, 4'hF);
        check("ir_capture_tdo", ir_out, 4'b0001);
        tck_bit(1, 0, t);
        check("ir_after_update", IR, 4'hA);
        tck_bit(0, 0, t);
        check("idle_state", STATE, 4'h0);

        CAP_DATA = 35'h5_1234_5678;
        c0 = cap_cnt; u0 = upd_cnt;
        shift_dr(64'h2_DEAD_BEEF, 35, dout);
        check("user_tdo_stream", dout, 64'h5_1234_5678);
        check("user_cap_pulses", cap_cnt - c0, 1);
        check("user_upd_pulses", upd_cnt - u0, 1);
        check("user_upd_data", UPD_DATA, 35'h2_DEAD_BEEF);

        u0 = upd_cnt;
        repeat (300) @(negedge CLK);
        check("gated_state", STATE, 4'h0);
        check("gated_upd_data", UPD_DATA, 35'h2_DEAD_BEEF);
        check("gated_no_upd", upd_cnt - u0, 0);

        CAP_DATA = 35'h1_5555_AAAA;
        din = 35'h3_0F0F_1234;
        dout = '0;
        c0 = cap_cnt; u0 = upd_cnt;
        tck_bit(1, 0, t); tck_bit(0, 0, t); tck_bit(0, 0, t);
        for (int i = 0; i < 20; i++) begin
            tck_bit(i == 19, din[i], t);
            dout[i] = t;
        end
        tck_bit(0, 0, t);
        check("pause_state", STATE, 4'h6);
        repeat (10) tck_bit(0, 1, t);
        check("pause_hold_state", STATE, 4'h6);
        check("pause_oe", TDO_OE, 0);
        tck_bit(1, 0, t);
        check("exit2_state", STATE, 4'h7);
        tck_bit(0, 0, t);
        for (int i = 20; i < 35; i++) begin
            tck_bit(i == 34, din[i], t);
            dout[i] = t;
        end
        tck_bit(1, 0, t); tck_bit(0, 0, t);
        check("pause_tdo_stream", dout, 64'h1_5555_AAAA);
        check("pause_upd_data", UPD_DATA, 35'h3_0F0F_1234);
        check("pause_upd_pulses", upd_cnt - u0, 1);
        check("pause_cap_pulses", cap_cnt - c0, 1);

        u0 = upd_cnt;
        tck_bit(1, 0, t); tck_bit(0, 0, t); tck_bit(0, 0, t);
        for (int i = 0; i < 17; i++) tck_bit(0, din[i], t);
        @(negedge CLK);
        TCK = 1'b0;
        SYS_RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        SYS_RESETn = 1'b1;
        repeat (20) @(negedge CLK);
        check("midrst_state", STATE, 4'h8);
        check("midrst_ir", IR, 4'hE);
        check("midrst_no_upd", upd_cnt - u0, 0);
        check("midrst_tap_resetn", TAP_RESETn, 0);
        check("midrst_upd_data", UPD_DATA, 0);
        check("midrst_tdo_oe", TDO_OE, 0);
        tck_bit(0, 0, t);
        check("midrst_idle", STATE, 4'h0);
        check("idle_tap_resetn", TAP_RESETn, 1);

        tck_bit(1, 0, t); tck_bit(1, 0, t); tck_bit(0, 0, t);
        tck_bit(0, 0, t); tck_bit(1, 0, t); tck_bit(0, 0, t);
        check("pause_ir_state", STATE, 4'hE);
        repeat (5) tck_bit(1, 0, t);
        check("tms5_state", STATE, 4'h8);
        check("tms5_tap_resetn", TAP_RESETn, 0);
        check("tms5_ir", IR, 4'hE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
